// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM; define JAL_EN to enable the JAL state (opcode 000011)
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       JR,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       BranchEQ,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       Illegal,
  output logic [3:0] State
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11,
`ifdef JAL_EN
    JAL       = 4'd12,
`endif
    ILLEGAL   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
`ifdef JAL_EN
  localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_beq;
  logic       w_bne;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_illegal;
  logic [3:0] w_iop;

  // ALU operation for the immediate-arithmetic group; addi is the fallback
  assign w_iop = (Opcode == OP_ORI)  ? 4'b0101 :
                 (Opcode == OP_ANDI) ? 4'b0110 :
                 (Opcode == OP_LUI)  ? 4'b1000 : 4'b0100;

  // State register; reset aborts any pending memory handshake
  always_ff @(posedge clk) begin
    r_state <= !reset ? FETCH : w_next;
  end

  // Next-state and control outputs for the current state
  always_comb begin
    w_next     = FETCH;
    w_pcwrite  = 1'b0;
    w_beq      = 1'b0;
    w_bne      = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    IorD       = 1'b0;
    MemtoReg   = 2'b00;
    RegDst     = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSource   = 2'b00;
    ALUOp      = 4'b0100;
    case (r_state)
      FETCH: begin
        w_memread = 1'b1;
        ALUSrcB   = 2'b01;
        w_irwrite = MemReady;
        w_pcwrite = MemReady;
        w_next    = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_R:                             w_next = R_EXEC;
          OP_LW, OP_SW:                     w_next = MEM_ADDR;
          OP_BEQ, OP_BNE:                   w_next = BRANCH;
          OP_J:                             w_next = JUMP;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: w_next = I_EXEC;
`ifdef JAL_EN
          OP_JAL:                           w_next = JAL;
`endif
          default:                          w_next = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (Opcode == OP_LW) ? 4'b0010 : 4'b0011;
        w_next  = (Opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        w_memread = 1'b1;
        IorD      = 1'b1;
        w_next    = MemReady ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        w_regwrite = 1'b1;
        MemtoReg   = 2'b01;
      end
      MEM_WRITE: begin
        w_memwrite = 1'b1;
        IorD       = 1'b1;
        w_next     = MemReady ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 4'b0111;
        w_pcwrite = JR;
        PCSource  = JR ? 2'b11 : 2'b00;
        w_next    = JR ? FETCH : R_WB;
      end
      R_WB: begin
        w_regwrite = 1'b1;
        RegDst     = 2'b01;
        ALUOp      = 4'b0111;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 4'b0001;
        PCSource = 2'b01;
        w_beq    = (Opcode == OP_BEQ);
        w_bne    = (Opcode == OP_BNE);
      end
      JUMP: begin
        w_pcwrite = 1'b1;
        PCSource  = 2'b10;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = w_iop;
        w_next  = I_WB;
      end
      I_WB: begin
        w_regwrite = 1'b1;
        ALUOp      = w_iop;
      end
`ifdef JAL_EN
      JAL: begin
        w_pcwrite  = 1'b1;
        PCSource   = 2'b10;
        w_regwrite = 1'b1;
        RegDst     = 2'b10;
        MemtoReg   = 2'b10;
      end
`endif
      ILLEGAL: begin
        w_illegal = 1'b1;
        w_next    = ILLEGAL;
      end
      default: w_next = FETCH;
    endcase
  end

  // Strobes are forced low while reset is asserted
  assign PCWrite  = reset & w_pcwrite;
  assign BranchEQ = reset & w_beq;
  assign BranchNE = reset & w_bne;
  assign MemRead  = reset & w_memread;
  assign MemWrite = reset & w_memwrite;
  assign IRWrite  = reset & w_irwrite;
  assign RegWrite = reset & w_regwrite;
  assign Illegal  = reset & w_illegal;
  assign State    = r_state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control (honours JAL_EN)
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       JR = 1'b0;
  logic       MemReady = 1'b1;
  logic       PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] MemtoReg, RegDst;
  logic       RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic       Illegal;
  logic [3:0] State;
  logic [25:0] w_obs;

  typedef struct {
    string       tag;
    logic [25:0] e;
  } item_t;

  item_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .JR(JR), .MemReady(MemReady),
    .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  assign w_obs = {State, PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal};

  // strb = {PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite}
  function automatic logic [25:0] ev(input logic [3:0] st, input logic [6:0] strb,
                                     input logic [1:0] m2r, input logic [1:0] rd,
                                     input logic rw, input logic sa, input logic [1:0] sb_,
                                     input logic [1:0] ps, input logic [3:0] op, input logic ill);
    return {st, strb, m2r, rd, rw, sa, sb_, ps, op, ill};
  endfunction

  task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rs, input logic [5:0] op, input logic jr,
                     input logic mr, input logic [25:0] e);
    item_t it;
    @(negedge clk);
    reset = rs;
    Opcode = op;
    JR = jr;
    MemReady = mr;
    sb.push_back('{tag, e});
    #2;
    it = sb.pop_front();
    chk(it.tag, w_obs, it.e);
  endtask

  task automatic fetch_decode(input string tag, input logic [5:0] op);
    cyc({tag, "_fetch"}, 1'b1, op, 1'b0, 1'b1, ev(4'd0, 7'b1000101, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0100, 1'b0));
    cyc({tag, "_decode"}, 1'b1, op, 1'b0, 1'b1, ev(4'd1, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 4'b0100, 1'b0));
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      cyc("reset_hold", 1'b0, 6'b100011, 1'b0, 1'b1, ev(4'd0, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0100, 1'b0));
    fetch_decode("lw", 6'b100011);
    cyc("lw_addr", 1'b1, 6'b100011, 1'b0, 1'b1, ev(4'd2, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 4'b0010, 1'b0));
    cyc("lw_read", 1'b1, 6'b100011, 1'b0, 1'b1, ev(4'd3, 7'b0001100, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100, 1'b0));
    cyc("lw_wb", 1'b1, 6'b100011, 1'b0, 1'b1, ev(4'd4, 7'b0000000, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0100, 1'b0));
    for (int i = 0; i < 3; i++)
      cyc("fetch_wait", 1'b1, 6'b000000, 1'b1, 1'b0, ev(4'd0, 7'b0000100, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0100, 1'b0));
    fetch_decode("jr", 6'b000000);
    cyc("jr_exec", 1'b1, 6'b000000, 1'b1, 1'b1, ev(4'd6, 7'b1000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b11, 4'b0111, 1'b0));
    fetch_decode("bne", 6'b000101);
    cyc("bne_br", 1'b1, 6'b000101, 1'b0, 1'b1, ev(4'd8, 7'b0010000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 4'b0001, 1'b0));
    fetch_decode("beq", 6'b000100);
    cyc("beq_br", 1'b1, 6'b000100, 1'b0, 1'b1, ev(4'd8, 7'b0100000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 4'b0001, 1'b0));
    fetch_decode("rtype", 6'b000000);
    cyc("r_exec", 1'b1, 6'b000000, 1'b0, 1'b1, ev(4'd6, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 4'b0111, 1'b0));
    cyc("r_wb", 1'b1, 6'b000000, 1'b0, 1'b1, ev(4'd7, 7'b0000000, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0111, 1'b0));
    fetch_decode("sw", 6'b101011);
    cyc("sw_addr", 1'b1, 6'b101011, 1'b0, 1'b0, ev(4'd2, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 4'b0011, 1'b0));
    cyc("sw_wait", 1'b1, 6'b101011, 1'b0, 1'b0, ev(4'd5, 7'b0001010, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100, 1'b0));
    cyc("sw_done", 1'b1, 6'b101011, 1'b0, 1'b1, ev(4'd5, 7'b0001010, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100, 1'b0));
    fetch_decode("sw_abort", 6'b101011);
    cyc("swab_addr", 1'b1, 6'b101011, 1'b0, 1'b0, ev(4'd2, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 4'b0011, 1'b0));
    cyc("swab_reset", 1'b0, 6'b101011, 1'b0, 1'b0, ev(4'd5, 7'b0001000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100, 1'b0));
    cyc("swab_after", 1'b0, 6'b101011, 1'b0, 1'b0, ev(4'd0, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0100, 1'b0));
    fetch_decode("ori", 6'b001101);
    cyc("ori_exec", 1'b1, 6'b001101, 1'b0, 1'b1, ev(4'd10, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 4'b0101, 1'b0));
    cyc("ori_wb", 1'b1, 6'b001101, 1'b0, 1'b1, ev(4'd11, 7'b0000000, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0101, 1'b0));
    fetch_decode("lui", 6'b001111);
    cyc("lui_exec", 1'b1, 6'b001111, 1'b0, 1'b1, ev(4'd10, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 4'b1000, 1'b0));
    cyc("lui_wb", 1'b1, 6'b001111, 1'b0, 1'b1, ev(4'd11, 7'b0000000, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 4'b1000, 1'b0));
    fetch_decode("j", 6'b000010);
    cyc("j_jump", 1'b1, 6'b000010, 1'b0, 1'b1, ev(4'd9, 7'b1000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 4'b0100, 1'b0));
    fetch_decode("ill", 6'b111111);
    for (int i = 0; i < 10; i++)
      cyc("ill_hold", 1'b1, 6'b000000, 1'b0, 1'b1, ev(4'd13, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100, 1'b1));
    cyc("ill_reset", 1'b0, 6'b000000, 1'b0, 1'b1, ev(4'd13, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100, 1'b0));
    fetch_decode("jal", 6'b000011);
`ifdef JAL_EN
    cyc("jal_state", 1'b1, 6'b000011, 1'b0, 1'b1, ev(4'd12, 7'b1000000, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 2'b10, 4'b0100, 1'b0));
`else
    cyc("jal_illegal", 1'b1, 6'b000011, 1'b0, 1'b1, ev(4'd13, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100, 1'b1));
    cyc("jal_reset", 1'b0, 6'b000011, 1'b0, 1'b1, ev(4'd13, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100, 1'b0));
`endif
    cyc("final_fetch", 1'b1, 6'b000000, 1'b0, 1'b1, ev(4'd0, 7'b1000101, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0100, 1'b0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The module SHALL have no parameters; one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-low reset.
REQ-004 Opcode  in  6  instruction[31:26], sampled in DECODE.
REQ-005 JR  in  1  jump-register flag from ALU control, sampled in R_EXEC.
REQ-006 MemReady  in  1  memory completion handshake.
REQ-007 PCWrite  out  1  unconditional PC load.
REQ-008 BranchEQ  out  1  conditional PC load on zero.
REQ-009 BranchNE  out  1  conditional PC load on non-zero.
REQ-010 IorD  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-011 MemRead  out  1  memory read request.
REQ-012 MemWrite  out  1  memory write request.
REQ-013 IRWrite  out  1  instruction register load.
REQ-014 MemtoReg  out  2  write-back data: 00=ALUOut, 01=MDR, 10=PC.
REQ-015 RegDst  out  2  write register: 00=rt, 01=rd, 10=$31.
REQ-016 RegWrite  out  1  register file write.
REQ-017 ALUSrcA  out  1  0=PC, 1=rs.
REQ-018 ALUSrcB  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2.
REQ-019 PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs.
REQ-020 ALUOp  out  4  to ALU control: 0111 R, 0100 add, 0101 or, 0110 and, 0001 sub, 0010 lw, 0011 sw, 1000 lui.
REQ-021 Illegal  out  1  unsupported opcode trap.
REQ-022 State  out  4  current state encoding (debug).

Function
REQ-023 States SHALL be FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, JAL=12, ILLEGAL=13; codes 14-15 SHALL go to FETCH.
REQ-024 Outputs not listed for a state SHALL be 0; ALUOp defaults to 0100.
REQ-025 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSource=00; IRWrite=PCWrite=MemReady; hold FETCH while MemReady=0, go to DECODE the cycle after MemReady=1.
REQ-026 DECODE: ALUSrcA=0, ALUSrcB=11; next by Opcode: 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100/000101->BRANCH, 000010->JUMP, 001000/001101/001100/001111->I_EXEC, 000011->JAL, other->ILLEGAL.
REQ-027 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=0010 for lw / 0011 for sw (Opcode held stable by IR); next MEM_READ for lw, MEM_WRITE for sw.
REQ-028 MEM_READ: MemRead=1, IorD=1; hold until MemReady=1, then MEM_WB.
REQ-029 MEM_WB: RegWrite=1, MemtoReg=01, RegDst=00; next FETCH.
REQ-030 MEM_WRITE: MemWrite=1, IorD=1; hold until MemReady=1, then FETCH.
REQ-031 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=0111; if JR=1: PCWrite=1, PCSource=11, next FETCH; else next R_WB.
REQ-032 R_WB: RegWrite=1, RegDst=01, MemtoReg=00, ALUOp=0111; next FETCH.
REQ-033 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0001, PCSource=01, BranchEQ=1 for 000100 / BranchNE=1 for 000101; next FETCH.
REQ-034 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-035 I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp 0100/0101/0110/1000 for addi/ori/andi/lui; next I_WB; I_WB: RegWrite=1, RegDst=00, MemtoReg=00, same ALUOp; next FETCH.
REQ-036 JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; next FETCH.
REQ-037 ILLEGAL: Illegal=1, all strobes 0, SHALL remain until reset.

Reset
REQ-038 While reset=0 at a rising edge, state SHALL become FETCH, including mid-handshake (pending MemRead/MemWrite abandoned).
REQ-039 While reset=0, PCWrite, BranchEQ, BranchNE, MemRead, MemWrite, IRWrite, RegWrite, Illegal SHALL be 0; State SHALL read 0 after the edge.

Configuration
REQ-040 With JAL_EN defined, opcode 000011 SHALL decode to JAL per REQ-036.
REQ-041 Without JAL_EN, JAL state SHALL be absent, 000011 SHALL go to ILLEGAL, RegDst=10 and MemtoReg=10 SHALL never occur.

Verification
REQ-042 reset=0 two cycles, MemReady=1 -> State=0, strobes 0; first cycle after release MemRead=IRWrite=PCWrite=1, ALUOp=0100.
REQ-043 Opcode 100011, MemReady=1 -> States 0,1,2,3,4,0; RegWrite=1 only in 4 with MemtoReg=01, RegDst=00.
REQ-044 FETCH with MemReady=0 three cycles then 1 -> FETCH held 4 cycles, IRWrite single pulse in 4th.
REQ-045 Opcode 000000, JR=1 -> States 0,1,6,0; PCWrite=1, PCSource=11 in 6; RegWrite never 1.
REQ-046 Opcode 000101 -> States 0,1,8,0; BranchNE=1, ALUOp=0001, ALUSrcB=00 in 8.
REQ-047 Opcode 111111 -> State 13, Illegal=1 for 10 cycles until reset; opcode 000011 -> State 12 with JAL_EN, 13 without.
